// File: rtl/adder_arbiter_pkg.sv
// adder_arb_pkg: state encoding and default sizing shared by the adder_arbiter slice
package adder_arb_pkg;
  localparam int NREQ_DEF = 4;
  localparam int WIDTH_DEF = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
endpackage

// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: request, shared-adder and response signals of adder_arbiter
// master = clients/adder side, slave = arbiter side
interface adder_arbiter_if
  import adder_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0] req_valid_i;
  logic [NREQ*WIDTH-1:0] req_a_i;
  logic [NREQ*WIDTH-1:0] req_b_i;
  logic [NREQ-1:0] req_ready_o;
  logic [WIDTH-1:0] add_a_o;
  logic [WIDTH-1:0] add_b_o;
  logic [WIDTH:0] add_s_i;
  logic rsp_valid_o;
  logic [IW-1:0] rsp_id_o;
  logic [WIDTH:0] rsp_sum_o;
  logic rsp_ready_i;
  logic busy_o;
  modport master (
    output req_valid_i, req_a_i, req_b_i, add_s_i, rsp_ready_i,
    input req_ready_o, add_a_o, add_b_o, rsp_valid_o, rsp_id_o, rsp_sum_o, busy_o
  );
  modport slave (
    input req_valid_i, req_a_i, req_b_i, add_s_i, rsp_ready_i,
    output req_ready_o, add_a_o, add_b_o, rsp_valid_o, rsp_id_o, rsp_sum_o, busy_o
  );
endinterface

// File: rtl/adder_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at prio_ptr_i, wrapping modulo NREQ
// req_i: request vector; prio_ptr_i: first index searched; en_i: gates gnt_o
// gnt_o: one-hot grant; gnt_idx_o: granted index; any_req_o: some request present
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] prio_ptr_i,
  input  logic                    en_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] gnt_idx_o,
  output logic                    any_req_o
);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0] rot;
  logic [IW-1:0] off;
  logic [IW:0] sum;
  // rotate so bit 0 is the requester at prio_ptr_i; the lowest set bit is the winner's offset
  assign rot = NREQ'({req_i, req_i} >> prio_ptr_i);
  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (rot[i]) off = IW'(i);
  end
  assign sum = {1'b0, prio_ptr_i} + {1'b0, off};
  assign gnt_idx_o = sum >= (IW+1)'(NREQ) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
  assign any_req_o = |req_i;
  assign gnt_o = (en_i && any_req_o) ? NREQ'(1) << gnt_idx_o : '0;
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sequencer sharing one external combinational adder among NREQ requesters
// clk_i/rst_ni: clock and synchronous active-low reset
// bus.req_*: per-requester valid/ready + packed operands; bus.add_*: shared adder hookup
// bus.rsp_*: registered sum tagged with requester index; bus.busy_o: not idle
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input logic clk_i,
  input logic rst_ni,
  adder_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  state_e state_q, state_d;
  logic [IW-1:0] prio_q, prio_d, id_q, id_d, gnt_idx;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [WIDTH:0] sum_q, sum_d;
  logic [NREQ-1:0] gnt;
  logic any_req;
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i(bus.req_valid_i),
    .prio_ptr_i(prio_q),
    .en_i(state_q == IDLE),
    .gnt_o(gnt),
    .gnt_idx_o(gnt_idx),
    .any_req_o(any_req)
  );
  always_comb begin
    state_d = state_q;
    prio_d = prio_q;
    id_d = id_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    sum_d = sum_q;
    unique case (state_q)
      IDLE: if (any_req) begin
        state_d = ISSUE;
        prio_d = gnt_idx == IW'(NREQ - 1) ? '0 : gnt_idx + IW'(1);
        id_d = gnt_idx;
        op_a_d = bus.req_a_i[gnt_idx*WIDTH +: WIDTH];
        op_b_d = bus.req_b_i[gnt_idx*WIDTH +: WIDTH];
      end
      ISSUE: begin
        state_d = RESP;
        sum_d = bus.add_s_i;
      end
      RESP: state_d = bus.rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prio_q <= '0;
      id_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      sum_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      id_q <= id_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      sum_q <= sum_d;
    end
  end
  // adder inputs come straight from the operand registers so they only move on acceptance
  assign bus.add_a_o = op_a_q;
  assign bus.add_b_o = op_b_q;
  assign bus.req_ready_o = gnt;
  assign bus.rsp_valid_o = state_q == RESP;
  assign bus.rsp_id_o = id_q;
  assign bus.rsp_sum_o = sum_q;
  assign bus.busy_o = state_q != IDLE;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and random stimulus against a transaction-level model of adder_arbiter
module tb_adder_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  adder_arbiter_if #(.NREQ(N), .WIDTH(W)) bus();
  adder_arbiter #(.NREQ(N), .WIDTH(W)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.add_s_i = {1'b0, bus.add_a_o} + {1'b0, bus.add_b_o};
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  // model: one operation in flight; age counts cycles since acceptance (1 = add, 2 = response)
  bit m_ok = 0, m_busy = 0, m_zero = 0;
  int m_ptr = 0, m_age = 0, m_id = 0, m_sum = 0, m_a = 0, m_b = 0;
  always @(negedge clk) begin
    int g;
    g = -1;
    if (!m_busy)
      for (int o = 0; o < N; o++)
        if (g < 0 && bus.req_valid_i[(m_ptr + o) % N]) g = (m_ptr + o) % N;
    if (m_ok) begin
      chk("m_ready", int'(bus.req_ready_o), g < 0 ? 0 : (1 << g));
      chk("m_busy", int'(bus.busy_o), int'(m_busy));
      chk("m_rsp_valid", int'(bus.rsp_valid_o), int'(m_busy && m_age == 2));
      chk("m_add_a", int'(bus.add_a_o), m_a);
      chk("m_add_b", int'(bus.add_b_o), m_b);
      if ((m_busy && m_age == 2) || m_zero) begin
        chk("m_rsp_id", int'(bus.rsp_id_o), m_id);
        chk("m_rsp_sum", int'(bus.rsp_sum_o), m_sum);
      end
    end
    if (!rst_n) begin
      m_ok = 1; m_busy = 0; m_ptr = 0; m_a = 0; m_b = 0; m_id = 0; m_sum = 0; m_zero = 1;
    end else if (m_ok) begin
      if (!m_busy) begin
        if (g >= 0) begin
          m_busy = 1; m_age = 1; m_id = g; m_zero = 0;
          m_a = int'(bus.req_a_i[g*W +: W]);
          m_b = int'(bus.req_b_i[g*W +: W]);
          m_sum = m_a + m_b;
          m_ptr = (g + 1) % N;
        end
      end else if (m_age == 1) m_age = 2;
      else if (bus.rsp_ready_i) m_busy = 0;
    end
  end
  task automatic single(input int k, input int a, input int b, input int s);
    @(posedge clk); #1;
    bus.req_valid_i = N'(1) << k;
    bus.req_a_i[k*W +: W] = W'(a);
    bus.req_b_i[k*W +: W] = W'(b);
    @(negedge clk);
    chk("single_ready", int'(bus.req_ready_o), 1 << k);
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    @(negedge clk);
    chk("single_issue_busy", int'(bus.busy_o), 1);
    chk("single_issue_valid", int'(bus.rsp_valid_o), 0);
    @(negedge clk);
    chk("single_rsp_valid", int'(bus.rsp_valid_o), 1);
    chk("single_rsp_id", int'(bus.rsp_id_o), k);
    chk("single_rsp_sum", int'(bus.rsp_sum_o), s);
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy_o && n < 30);
    chk("idle_reached", int'(bus.busy_o), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end
  initial begin
    logic [N-1:0] r;
    int gi[$], gc[$];
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    bus.req_valid_i = '0;
    bus.req_a_i = '0;
    bus.req_b_i = '0;
    bus.rsp_ready_i = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid_o), 0);
    chk("rst_add_a", int'(bus.add_a_o), 0);
    chk("rst_rsp_sum", int'(bus.rsp_sum_o), 0);
    single(2, 3, 4, 7);
    single(0, 15, 15, 30);
    single(0, 8, 8, 16);
    single(3, 7, 2, 9);
    repeat (10) begin
      @(negedge clk);
      chk("idle_busy", int'(bus.busy_o), 0);
      chk("idle_ready", int'(bus.req_ready_o), 0);
      chk("idle_rsp_valid", int'(bus.rsp_valid_o), 0);
      chk("idle_add_a", int'(bus.add_a_o), 7);
      chk("idle_add_b", int'(bus.add_b_o), 2);
    end
    @(posedge clk); #1;
    bus.req_valid_i = '1;
    bus.req_a_i = (N*W)'($urandom);
    bus.req_b_i = (N*W)'($urandom);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      r = bus.req_ready_o;
      for (int k = 0; k < N; k++) if (r[k]) begin gi.push_back(k); gc.push_back(c); end
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) if (r[k]) begin
        bus.req_a_i[k*W +: W] = W'($urandom);
        bus.req_b_i[k*W +: W] = W'($urandom);
      end
    end
    bus.req_valid_i = '0;
    chk("fair_count", gi.size(), 6);
    for (int i = 0; i < gi.size() && i < 6; i++) begin
      chk("fair_order", gi[i], exp_order[i]);
      chk("fair_spacing", gc[i], 3 * i);
    end
    wait_idle();
    @(posedge clk); #1;
    bus.rsp_ready_i = 0;
    bus.req_valid_i = 4'b0010;
    bus.req_a_i[1*W +: W] = 4'h2;
    bus.req_b_i[1*W +: W] = 4'h9;
    @(negedge clk);
    chk("bp_accept", int'(bus.req_ready_o), 2);
    @(posedge clk); #1;
    bus.req_valid_i = 4'b0100;
    bus.req_a_i[2*W +: W] = 4'h1;
    bus.req_b_i[2*W +: W] = 4'h1;
    @(negedge clk);
    chk("bp_issue_ready", int'(bus.req_ready_o), 0);
    repeat (5) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_valid", int'(bus.rsp_valid_o), 1);
      chk("bp_id", int'(bus.rsp_id_o), 1);
      chk("bp_sum", int'(bus.rsp_sum_o), 11);
      chk("bp_ready", int'(bus.req_ready_o), 0);
    end
    @(posedge clk); #1;
    bus.rsp_ready_i = 1;
    @(negedge clk);
    chk("bp_hs_valid", int'(bus.rsp_valid_o), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_next_accept", int'(bus.req_ready_o), 4);
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    wait_idle();
    @(posedge clk); #1;
    bus.req_valid_i = 4'b0001;
    bus.req_a_i[0 +: W] = 4'h5;
    bus.req_b_i[0 +: W] = 4'h6;
    @(negedge clk);
    chk("rm_accept", int'(bus.req_ready_o), 1);
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    rst_n = 0;
    @(negedge clk);
    chk("rm_issue_busy", int'(bus.busy_o), 1);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("rm_ready", int'(bus.req_ready_o), 0);
    chk("rm_rsp_valid", int'(bus.rsp_valid_o), 0);
    chk("rm_busy", int'(bus.busy_o), 0);
    chk("rm_add_a", int'(bus.add_a_o), 0);
    chk("rm_add_b", int'(bus.add_b_o), 0);
    chk("rm_rsp_sum", int'(bus.rsp_sum_o), 0);
    chk("rm_rsp_id", int'(bus.rsp_id_o), 0);
    @(posedge clk); #1;
    bus.req_valid_i = 4'b1010;
    @(negedge clk);
    chk("rm_first_grant", int'(bus.req_ready_o), 2);
    @(posedge clk); #1;
    bus.req_valid_i = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    chk("rm_rsp_id1", int'(bus.rsp_id_o), 1);
    @(negedge clk);
    chk("rm_second_grant", int'(bus.req_ready_o), 8);
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    wait_idle();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      r = bus.req_ready_o;
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (!bus.req_valid_i[k] || r[k]) begin
          bus.req_valid_i[k] = $urandom_range(0, 2) == 0;
          bus.req_a_i[k*W +: W] = W'($urandom);
          bus.req_b_i[k*W +: W] = W'($urandom);
        end else if ($urandom_range(0, 3) == 0) begin
          bus.req_a_i[k*W +: W] = W'($urandom);
          bus.req_b_i[k*W +: W] = W'($urandom);
        end
      end
      bus.rsp_ready_i = $urandom_range(0, 2) != 0;
      rst_n = $urandom_range(0, 199) != 0;
    end
    bus.req_valid_i = '0;
    bus.rsp_ready_i = 1;
    rst_n = 1;
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one combinational `adder` instance between NREQ requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the winner's operands onto the shared adder. It registers the sum and returns it, tagged with the requester index, over a valid/ready response channel. The arbiter sits between client agents and the `adder` in the adder environment top level, replacing the direct interface-to-DUT hookup.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 4: operand width; the sum is WIDTH+1 bits (carry in MSB).
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i  in  NREQ  per-requester request valid.
- req_a_i  in  NREQ*WIDTH  operand A, packed; requester k occupies [k*WIDTH +: WIDTH].
- req_b_i  in  NREQ*WIDTH  operand B, packed the same way.
- req_ready_o  out  NREQ  one-hot acceptance strobe.
- add_a_o  out  WIDTH  operand A to shared adder a_i.
- add_b_o  out  WIDTH  operand B to shared adder b_i.
- add_s_i  in  WIDTH+1  sum from shared adder s_o, combinational from add_a_o/add_b_o.
- rsp_valid_o  out  1  response valid.
- rsp_id_o  out  $clog2(NREQ)  index of the requester that owns the response.
- rsp_sum_o  out  WIDTH+1  registered sum.
- rsp_ready_i  in  1  response consumer ready.
- busy_o  out  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid_i is set, grant one requester g by round-robin. The search starts at prio_ptr and wraps modulo NREQ.
  - req_ready_o[g]=1 combinationally in this cycle only. This is the handshake cycle.
  - Latch A[g] into op_a_q, B[g] into op_b_q, and g into id_q. Set prio_ptr to (g+1) mod NREQ. Go to ISSUE.
  - If no request is valid: stay in IDLE, with req_ready_o=0 and prio_ptr unchanged.
- ISSUE: add_a_o/add_b_o = op_a_q/op_b_q. Capture add_s_i into sum_q. Go to RESP.
- RESP:
  - rsp_valid_o=1, rsp_id_o=id_q, rsp_sum_o=sum_q. These hold stable until rsp_ready_i=1.
  - On rsp_valid_o && rsp_ready_i, go to IDLE.
  - No new request is accepted in RESP, including in the handshake cycle.
- add_a_o/add_b_o are driven from op_a_q/op_b_q in every state, so the adder inputs change only on acceptance.
- req_ready_o is 0 in ISSUE and RESP.
- Requester inputs may change freely while unaccepted. A requester drops valid only after it sees its ready strobe.
- Arithmetic: unsigned. sum = {carry, WIDTH-bit sum}; for example, 4'hF+4'hF = 5'h1E.
- The arbiter does not check add_s_i; a wrong adder result passes through unmodified.

## Timing
- Accept at cycle T, ISSUE at T+1, rsp_valid_o at T+2 at the earliest.
- Peak throughput is one operation per 3 cycles with rsp_ready_i held high.
- Back-to-back: the RESP handshake at cycle C returns to IDLE at C+1. A pending request is accepted at C+1.
- Fairness: with all NREQ requesters continuously valid, grants go 0,1,2,...,NREQ-1,0,... Any requester is served within NREQ grants.
- Reset (rst_ni=0 at an edge), in any state including mid-ISSUE or mid-RESP:
  - Next cycle: state=IDLE, prio_ptr=0, and op_a_q, op_b_q, id_q, sum_q all 0.
  - Outputs: req_ready_o=0, rsp_valid_o=0, busy_o=0, add_a_o=add_b_o=0, rsp_sum_o=0, rsp_id_o=0.
  - An in-flight operation is discarded without a response.
  - The first grant after reset goes to the lowest-index valid requester.
- Simultaneous events:
  - rsp_ready_i high in the ISSUE cycle has no effect.
  - A request arriving in the same cycle as the RESP handshake waits until IDLE.

## Structure
- Package adder_arb_pkg holds the state enum (IDLE, ISSUE, RESP) and the NREQ/WIDTH default constants.
- Sub-module rr_arbiter (parameter NREQ): inputs req vector, prio_ptr and enable; outputs one-hot grant, grant index and any_req.
  - Purely combinational.
  - prio_ptr is updated in adder_arbiter.
- The shared `adder` stays outside the block and is connected at top level through add_a_o/add_b_o/add_s_i.

## Test plan
- Single request: requester 2 sends A=4'h3, B=4'h4.
  - req_ready_o=4'b0100 at T; rsp_valid_o at T+2 with rsp_id_o=2, rsp_sum_o=5'h07.
- Carry: A=4'hF, B=4'hF from requester 0 -> rsp_sum_o=5'h1E. A=4'h8, B=4'h8 -> 5'h10.
- Fairness: all 4 requesters valid continuously, rsp_ready_i=1.
  - Grant order is 0,1,2,3,0,1.
  - Accept cycles are spaced exactly 3 apart.
- Backpressure: rsp_ready_i=0 for 5 cycles in RESP.
  - rsp_valid_o, rsp_id_o and rsp_sum_o hold stable; req_ready_o stays 0 despite a pending request.
  - The pending request is accepted the cycle after the handshake.
- Reset mid-operation: assert rst_ni=0 during ISSUE with A=4'h5, B=4'h6.
  - No response is produced; all outputs are 0 next cycle.
  - With requesters 1 and 3 valid after reset, the first grant goes to requester 1.
- Idle stability: no requests for 10 cycles.
  - busy_o=0, req_ready_o=0, rsp_valid_o=0; add_a_o/add_b_o hold the last accepted operands.
